rv_multicycle_ctrl: RTL
=======================

Name: rv_multicycle_ctrl

Overview:
Main control FSM for the multi-cycle RV32I core. It sequences fetch, decode, execute, memory and writeback. It drives every datapath select: PC, IR, register file, ALU operands and op, and writeback mux. It runs the request/acknowledge handshakes to instruction and data memory and counts retired instructions. The immediate generator and branch comparator are external; this block consumes the comparator result only.

Parameters:
CNT_W, 32, width of retired-instruction counter (wraps)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
opcode  in  7  IR[6:0], valid from DECODE onward (IR stable after ir_we)
funct3  in  3  IR[14:12]
funct7_b5  in  1  IR[30]
br_taken  in  1  branch comparator result, valid in EXEC
imem_ack  in  1  instruction memory done; instruction word on IR input this cycle
dmem_ack  in  1  data memory done; load data valid this cycle
imem_req  out  1  fetch request
ir_we  out  1  load IR
pc_we  out  1  load PC
pc_sel  out  2  PC source: 0 PC+4, 1 ALU result (branch/JAL target), 2 ALU result & ~1 (JALR)
alu_a_sel  out  2  0 rs1, 1 PC, 2 zero
alu_b_sel  out  1  0 rs2, 1 immediate
alu_op  out  4  ALU operation (package enum)
dmem_req  out  1  data access request
dmem_we  out  1  1 store, 0 load
reg_we  out  1  register file write
wb_sel  out  2  0 ALU, 1 load data, 2 PC+4
retire  out  1  one-cycle pulse per completed instruction
instret  out  CNT_W  retired-instruction count
illegal  out  1  sticky trap flag
state  out  3  current state, for debug

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP. Outputs are Moore, decoded from state plus opcode/funct inputs. Unlisted outputs are 0 in each state.
- Reset (async, any state, mid-transaction included): state=FETCH, instret=0, illegal=0. All outputs read 0 while rst_n=0. imem_req rises in the first cycle after release.
- FETCH: imem_req=1, held until imem_ack. On imem_ack (zero-wait allowed), ir_we=1 and go to DECODE.
- DECODE: one cycle for register file read. Legal opcodes are 0110011, 0010011, 0000011, 0100011, 1100011, 0110111, 0010111, 1101111, 1100111. Legal opcode -> EXEC; anything else -> TRAP.
- EXEC operand selection:
  - OP: a=rs1, b=rs2.
  - OP-IMM, LOAD, STORE, JALR: a=rs1, b=imm.
  - AUIPC, BRANCH, JAL: a=PC, b=imm.
  - LUI: a=zero, b=imm.
- EXEC alu_op:
  - OP: from funct3; funct7_b5 selects SUB (f3=000) / SRA (f3=101).
  - OP-IMM: from funct3; funct7_b5 honoured only for f3=101 (SRAI), so ADDI with IR[30]=1 stays ADD.
  - All other opcodes: ADD.
- EXEC transitions:
  - LOAD/STORE -> MEM.
  - BRANCH: pc_we=1, pc_sel = br_taken ? 1 : 0, retire, -> FETCH.
  - All others -> WB.
- MEM: dmem_req=1 and dmem_we=(STORE); ALU operand selects held so the address stays stable. Wait for dmem_ack:
  - store: pc_we=1, pc_sel=0, retire, -> FETCH.
  - load: -> WB.
- WB: reg_we=1 and pc_we=1, retire, -> FETCH. ALU selects held from EXEC.
  - wb_sel: LOAD=1; JAL/JALR=2; others 0.
  - pc_sel: JAL=1; JALR=2; others 0.
- TRAP: illegal=1; no requests or writes. Only reset exits.
- Acks are ignored when the matching req is low. A request is never withdrawn before its ack.
- retire: pulse on each completing edge. instret increments on the same edge and wraps from all-ones to 0.
- Latency with zero-wait memory:
  - branch: 3 cycles (FETCH, DECODE, EXEC)
  - ALU/U/J/store: 4 cycles
  - load: 5 cycles

Decomposition:
- Package rv_ctrl_pkg holds:
  - opcode constants
  - state enum
  - alu_op enum: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9
  - pc_sel, wb_sel, alu_a_sel constants
- Sub-module rv_alu_dec: combinational (opcode, funct3, funct7_b5) -> alu_op.

Test Plan:
- Reset: hold rst_n=0 with acks high -> all outputs 0, state=FETCH. Release -> imem_req=1 next cycle. Assert rst_n=0 mid-MEM -> dmem_req drops immediately.
- ADDI (0010011, f3=000, IR[30]=1), imem_ack after 2 waits -> imem_req high 3 cycles, then DECODE, then EXEC (alu_op=ADD, b_sel=1), then WB (reg_we=1, wb_sel=0, pc_sel=0). instret=1 after 6 cycles.
- OP f3=000 f7b5=1 -> SUB; OP-IMM f3=101 f7b5=1 -> SRA; OP f3=111 -> AND.
- LW with dmem_ack after 3 waits -> dmem_req high 4 cycles, dmem_we=0, then WB with wb_sel=1. SW -> dmem_we=1, reg_we never asserted, retire on the ack edge.
- BEQ with br_taken=1 -> EXEC asserts pc_we with pc_sel=1, a_sel=1; br_taken=0 -> pc_sel=0. JALR -> WB asserts wb_sel=2, pc_sel=2.
- Opcode 0000000 -> TRAP, illegal=1. Then toggle imem_ack/dmem_ack for 10 cycles -> no req/we outputs and instret unchanged.

Source files
------------

// File: rtl/rv_multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: opcodes, FSM states,
// ALU operations and datapath select codes.
package rv_ctrl_pkg;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   typedef enum logic [2:0] {
      ST_FETCH  = 3'd0,
      ST_DECODE = 3'd1,
      ST_EXEC   = 3'd2,
      ST_MEM    = 3'd3,
      ST_WB     = 3'd4,
      ST_TRAP   = 3'd5
   } state_t;

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;

   localparam logic [1:0] PC_PLUS4     = 2'd0;
   localparam logic [1:0] PC_ALU       = 2'd1;
   localparam logic [1:0] PC_ALU_ALIGN = 2'd2;

   localparam logic [1:0] WB_ALU  = 2'd0;
   localparam logic [1:0] WB_LOAD = 2'd1;
   localparam logic [1:0] WB_PC4  = 2'd2;

   localparam logic [1:0] A_RS1  = 2'd0;
   localparam logic [1:0] A_PC   = 2'd1;
   localparam logic [1:0] A_ZERO = 2'd2;

   localparam logic B_RS2 = 1'b0;
   localparam logic B_IMM = 1'b1;

   function automatic logic opc_legal(input logic [6:0] opc);
      case (opc)
         OPC_OP, OPC_OPIMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: opc_legal = 1'b1;
         default:                              opc_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/rv_multicycle_ctrl_alu_dec.sv
// ALU operation decode from opcode/funct fields; purely combinational, no handshake.
module rv_alu_dec
   import rv_ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_b5,
   output alu_op_t    alu_op
);

   logic w_is_op;

   assign w_is_op = (opcode == OPC_OP);

   always_comb begin
      alu_op = ALU_ADD;
      if (w_is_op || (opcode == OPC_OPIMM)) begin
         case (funct3)
            // IR[30] on ADDI is immediate data, so only register ops may subtract
            3'b000:  alu_op = (w_is_op && funct7_b5) ? ALU_SUB : ALU_ADD;
            3'b001:  alu_op = ALU_SLL;
            3'b010:  alu_op = ALU_SLT;
            3'b011:  alu_op = ALU_SLTU;
            3'b100:  alu_op = ALU_XOR;
            3'b101:  alu_op = funct7_b5 ? ALU_SRA : ALU_SRL;
            3'b110:  alu_op = ALU_OR;
            default: alu_op = ALU_AND;
         endcase
      end
   end

endmodule

// File: rtl/rv_multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: 3 cycles branch, 4 ALU/U/J/store, 5 load at zero wait.
// Memory waits stretch FETCH/MEM until the matching ack; all outputs forced low in reset.
module rv_multicycle_ctrl
   import rv_ctrl_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [6:0]       opcode,
   input  logic [2:0]       funct3,
   input  logic             funct7_b5,
   input  logic             br_taken,
   input  logic             imem_ack,
   input  logic             dmem_ack,
   output logic             imem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic [1:0]       alu_a_sel,
   output logic             alu_b_sel,
   output logic [3:0]       alu_op,
   output logic             dmem_req,
   output logic             dmem_we,
   output logic             reg_we,
   output logic [1:0]       wb_sel,
   output logic             retire,
   output logic [CNT_W-1:0] instret,
   output logic             illegal,
   output logic [2:0]       state
);

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_instret;
   logic             r_illegal;
   logic             w_retire;
   alu_op_t          w_dec_op;
   logic [1:0]       w_a_sel;
   logic             w_b_sel;
   logic             w_is_store;
   logic             w_is_mem;

   rv_alu_dec u_alu_dec (
      .opcode    (opcode),
      .funct3    (funct3),
      .funct7_b5 (funct7_b5),
      .alu_op    (w_dec_op)
   );

   assign w_is_store = (opcode == OPC_STORE);
   assign w_is_mem   = w_is_store || (opcode == OPC_LOAD);

   always_comb begin
      w_a_sel = A_RS1;
      w_b_sel = B_IMM;
      case (opcode)
         OPC_OP:                         w_b_sel = B_RS2;
         OPC_AUIPC, OPC_BRANCH, OPC_JAL: w_a_sel = A_PC;
         OPC_LUI:                        w_a_sel = A_ZERO;
         default:                        ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_FETCH;
         r_instret <= '0;
         r_illegal <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_retire)
            r_instret <= r_instret + CNT_W'(1);
         if (w_state_nxt == ST_TRAP)
            r_illegal <= 1'b1;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_retire    = 1'b0;
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = PC_PLUS4;
      alu_a_sel   = A_RS1;
      alu_b_sel   = B_RS2;
      alu_op      = ALU_ADD;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      reg_we      = 1'b0;
      wb_sel      = WB_ALU;
      if (rst_n) begin
         // ALU controls stay live past EXEC so address and writeback value hold still
         if (r_state inside {ST_EXEC, ST_MEM, ST_WB}) begin
            alu_a_sel = w_a_sel;
            alu_b_sel = w_b_sel;
            alu_op    = w_dec_op;
         end
         case (r_state)
            ST_FETCH: begin
               imem_req = 1'b1;
               if (imem_ack) begin
                  ir_we       = 1'b1;
                  w_state_nxt = ST_DECODE;
               end
            end
            ST_DECODE: w_state_nxt = opc_legal(opcode) ? ST_EXEC : ST_TRAP;
            ST_EXEC: begin
               if (w_is_mem) begin
                  w_state_nxt = ST_MEM;
               end else if (opcode == OPC_BRANCH) begin
                  pc_we       = 1'b1;
                  pc_sel      = br_taken ? PC_ALU : PC_PLUS4;
                  w_retire    = 1'b1;
                  w_state_nxt = ST_FETCH;
               end else begin
                  w_state_nxt = ST_WB;
               end
            end
            ST_MEM: begin
               dmem_req = 1'b1;
               dmem_we  = w_is_store;
               if (dmem_ack) begin
                  if (w_is_store) begin
                     pc_we       = 1'b1;
                     w_retire    = 1'b1;
                     w_state_nxt = ST_FETCH;
                  end else begin
                     w_state_nxt = ST_WB;
                  end
               end
            end
            ST_WB: begin
               reg_we      = 1'b1;
               pc_we       = 1'b1;
               w_retire    = 1'b1;
               w_state_nxt = ST_FETCH;
               case (opcode)
                  OPC_LOAD: wb_sel = WB_LOAD;
                  OPC_JAL:  begin wb_sel = WB_PC4; pc_sel = PC_ALU;       end
                  OPC_JALR: begin wb_sel = WB_PC4; pc_sel = PC_ALU_ALIGN; end
                  default:  ;
               endcase
            end
            ST_TRAP: ;
            default: w_state_nxt = ST_FETCH;
         endcase
      end
   end

   assign retire  = w_retire;
   assign instret = r_instret;
   assign illegal = r_illegal;
   assign state   = r_state;

endmodule
